// File: rtl/prog_seq.sv
// -----------------------------------------------------------------------------
// prog_seq -- program sequencer
//
// Owns the program counter, issues one instruction fetch at a time to the
// fetch/decode unit, resolves JMP / JZ / JNZ / HALT itself and forwards every
// other opcode to the execute datapath over a valid/done handshake.
//
// Ports
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   start              one-cycle run request, honoured in IDLE or HALT only
//   fetch_en, pc       fetch request and the address being fetched
//   is_ready           fetch/decode result valid (rising edge is the event)
//   control_bus, data  decoded opcode and immediate/target
//   zero_flag          datapath zero status, used by JZ / JNZ
//   ex_valid/op/arg    datapath command, held until ex_done
//   ex_done            datapath command complete
//   busy               FETCH, DECODE or EXEC
//   halted             HALT or FAULT
//   fault              FAULT (sticky until rstn)
//   retired            completed-instruction count, wraps modulo 2^16
// -----------------------------------------------------------------------------
module prog_seq #(
  parameter int  INST_CAP      = 20,
  parameter int  DATA_LEN      = 8,
  parameter int  FETCH_TIMEOUT = 15,
  localparam int PC_W          = $clog2(INST_CAP) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  output logic                fetch_en,
  output logic [PC_W-1:0]     pc,
  input  logic                is_ready,
  input  logic [3:0]          control_bus,
  input  logic [DATA_LEN-1:0] data,
  input  logic                zero_flag,
  output logic                ex_valid,
  output logic [3:0]          ex_op,
  output logic [DATA_LEN-1:0] ex_arg,
  input  logic                ex_done,
  output logic                busy,
  output logic                halted,
  output logic                fault,
  output logic [15:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JNZ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int              TMO_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);
  // pc == PC_LAST is the same condition as pc+1 == INST_CAP, without the
  // extra adder width.
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(INST_CAP - 1);

  state_t              state;
  logic [3:0]          op_r;
  logic [DATA_LEN-1:0] arg_r;
  logic                rdy_q;     // is_ready one cycle ago
  logic [TMO_W-1:0]    tmo;

  logic rdy_rise;
  logic is_branch;
  logic br_taken;
  logic tgt_bad;

  // NOTE: every signal gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rdy_rise  = is_ready & ~rdy_q;
    is_branch = 1'b0;
    br_taken  = 1'b0;
    case (op_r)
      OP_JMP: begin is_branch = 1'b1; br_taken = 1'b1;       end
      OP_JZ:  begin is_branch = 1'b1; br_taken = zero_flag;  end
      OP_JNZ: begin is_branch = 1'b1; br_taken = ~zero_flag; end
      default: ;
    endcase
    // The whole immediate is checked, not just the bits that fit in pc.
    tgt_bad = 32'(arg_r) >= INST_CAP;
  end

  // NOTE: state and outputs are sequential, so they are all written with
  // non-blocking assignments; every branch sees the pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      fetch_en <= 1'b0;
      pc       <= '0;
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_arg   <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      retired  <= '0;
      op_r     <= '0;
      arg_r    <= '0;
      rdy_q    <= 1'b0;
      tmo      <= '0;
    end else begin
      // History is tracked in every state so a level already high when FETCH
      // is entered never looks like a fresh result.
      rdy_q <= is_ready;

      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state    <= S_FETCH;
            pc       <= '0;
            retired  <= '0;
            fetch_en <= 1'b1;
            busy     <= 1'b1;
            halted   <= 1'b0;
            tmo      <= '0;
          end
        end

        S_FETCH: begin
          if (rdy_rise) begin
            op_r     <= control_bus;
            arg_r    <= data;
            fetch_en <= 1'b0;
            state    <= S_DECODE;
          end else if (tmo == TMO_LAST) begin
            // This is the FETCH_TIMEOUT-th fetch cycle without a result.
            state    <= S_FAULT;
            fetch_en <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b1;
            fault    <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        S_DECODE: begin
          if (op_r == OP_HALT) begin
            state   <= S_HALT;
            busy    <= 1'b0;
            halted  <= 1'b1;
            retired <= retired + 16'd1;
          end else if (is_branch) begin
            if ((br_taken && tgt_bad) || (!br_taken && pc == PC_LAST)) begin
              state  <= S_FAULT;
              busy   <= 1'b0;
              halted <= 1'b1;
              fault  <= 1'b1;
            end else begin
              pc       <= br_taken ? PC_W'(arg_r) : pc + 1'b1;
              retired  <= retired + 16'd1;
              fetch_en <= 1'b1;
              tmo      <= '0;
              state    <= S_FETCH;
            end
          end else begin
            ex_valid <= 1'b1;
            ex_op    <= op_r;
            ex_arg   <= arg_r;
            state    <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (ex_done) begin
            ex_valid <= 1'b0;
            retired  <= retired + 16'd1;
            if (pc == PC_LAST) begin
              // Falling off the end of instruction memory.
              state  <= S_FAULT;
              busy   <= 1'b0;
              halted <= 1'b1;
              fault  <= 1'b1;
            end else begin
              pc       <= pc + 1'b1;
              fetch_en <= 1'b1;
              tmo      <= '0;
              state    <= S_FETCH;
            end
          end
        end

        S_FAULT: ;  // sticky, only rstn leaves

        default: state <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_seq.sv
// -----------------------------------------------------------------------------
// tb_prog_seq -- self-checking bench for prog_seq
//
// The bench plays the fetch/decode unit (small instruction memory with a
// programmable latency) and the datapath (programmable completion latency).
// Each test pushes the fetch addresses and datapath commands it expects; a
// monitor pops and compares them as the sequencer issues them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_seq;

  localparam int INST_CAP      = 20;
  localparam int DATA_LEN      = 8;
  localparam int FETCH_TIMEOUT = 15;
  localparam int PC_W          = $clog2(INST_CAP) + 1;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic                fetch_en;
  logic [PC_W-1:0]     pc;
  logic                is_ready = 1'b0;
  logic [3:0]          control_bus = '0;
  logic [DATA_LEN-1:0] data = '0;
  logic                zero_flag = 1'b0;
  logic                ex_valid;
  logic [3:0]          ex_op;
  logic [DATA_LEN-1:0] ex_arg;
  logic                ex_done = 1'b0;
  logic                busy;
  logic                halted;
  logic                fault;
  logic [15:0]         retired;

  always #5 clk = ~clk;

  prog_seq #(
    .INST_CAP(INST_CAP), .DATA_LEN(DATA_LEN), .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .fetch_en(fetch_en), .pc(pc),
    .is_ready(is_ready), .control_bus(control_bus), .data(data),
    .zero_flag(zero_flag),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_arg(ex_arg), .ex_done(ex_done),
    .busy(busy), .halted(halted), .fault(fault), .retired(retired)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    bit is_ex;
    int a;     // fetch pc, or datapath opcode
    int b;     // datapath operand
  } exp_t;
  exp_t sbq[$];

  task automatic push_fetch(input int p);
    exp_t e; e.is_ex = 1'b0; e.a = p; e.b = 0; sbq.push_back(e);
  endtask

  task automatic push_ex(input int op, input int arg);
    exp_t e; e.is_ex = 1'b1; e.a = op; e.b = arg; sbq.push_back(e);
  endtask

  // ---------------- fetch/decode and datapath models ----------------
  logic [3:0]          mem_op  [64];
  logic [DATA_LEN-1:0] mem_arg [64];
  bit auto_fetch = 1'b1;
  int fetch_lat  = 0;
  int ex_lat     = 0;

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) begin
      mem_op[i]  = 4'hF;
      mem_arg[i] = '0;
    end
  endtask

  initial begin : fetch_unit
    int fwait;
    fwait = 0;
    forever begin
      @(negedge clk);
      if (auto_fetch) begin
        if (is_ready) begin
          is_ready = 1'b0;
        end else if (fetch_en && rstn) begin
          if (fwait < fetch_lat) begin
            fwait++;
          end else begin
            control_bus = mem_op[pc];
            data        = mem_arg[pc];
            is_ready    = 1'b1;
            fwait       = 0;
          end
        end else begin
          fwait = 0;
        end
      end
    end
  end

  initial begin : datapath
    int dwait;
    dwait = 0;
    forever begin
      @(negedge clk);
      if (ex_done) begin
        ex_done = 1'b0;
      end else if (ex_valid) begin
        if (dwait < ex_lat) dwait++;
        else begin
          ex_done = 1'b1;
          dwait   = 0;
        end
      end else begin
        dwait = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t       e;
    logic       fe_d, ev_d;
    logic [3:0] cur_op;
    logic [7:0] cur_arg;
    fe_d = 1'b0; ev_d = 1'b0; cur_op = '0; cur_arg = '0;
    forever begin
      @(negedge clk);
      if (fetch_en && !fe_d) begin
        check("sb_fetch_expected", sbq.size() > 0, 1'b1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("sb_fetch_kind", e.is_ex, 1'b0);
          check("fetch_pc", pc, e.a);
        end
      end
      if (ex_valid && !ev_d) begin
        check("sb_ex_expected", sbq.size() > 0, 1'b1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("sb_ex_kind", e.is_ex, 1'b1);
          check("ex_op", ex_op, e.a);
          check("ex_arg", ex_arg, e.b);
          cur_op  = e.a[3:0];
          cur_arg = e.b[7:0];
        end
      end else if (ex_valid) begin
        check("ex_op_hold", ex_op, cur_op);
        check("ex_arg_hold", ex_arg, cur_arg);
      end
      fe_d = fetch_en;
      ev_d = ex_valid;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_fetch_en", fetch_en, 1'b0);
    check("rst_pc", pc, 0);
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_op", ex_op, 0);
    check("rst_ex_arg", ex_arg, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_retired", retired, 0);
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int i;
    i = 0;
    while (!halted && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, halted, 1'b1);
  endtask

  // ---------------- tests ----------------
  initial begin : main
    clear_prog();
    #1;
    do_reset();

    // 1) ALU, ALU, HALT.
    clear_prog();
    mem_op[0] = 4'h1; mem_arg[0] = 8'd5;
    mem_op[1] = 4'h1; mem_arg[1] = 8'd5;
    fetch_lat = 1; ex_lat = 0;
    push_fetch(0); push_ex(1, 5); push_fetch(1); push_ex(1, 5); push_fetch(2);
    pulse_start();
    check("t1_busy", busy, 1'b1);
    wait_halted("t1_halt_seen", 200);
    check("t1_pc", pc, 2);
    check("t1_retired", retired, 3);
    check("t1_fault", fault, 1'b0);
    check("t1_busy_end", busy, 1'b0);
    check("t1_sb_drained", sbq.size(), 0);

    // 2) JMP 7 from HALT restart; no datapath command expected.
    clear_prog();
    mem_op[0] = 4'hC; mem_arg[0] = 8'd7;
    fetch_lat = 0;
    push_fetch(0); push_fetch(7);
    pulse_start();
    wait_halted("t2_halt_seen", 100);
    check("t2_pc", pc, 7);
    check("t2_retired", retired, 2);
    check("t2_sb_drained", sbq.size(), 0);

    // 3) JMP 25 is out of range -> sticky fault.
    clear_prog();
    mem_op[0] = 4'hC; mem_arg[0] = 8'd25;
    push_fetch(0);
    pulse_start();
    wait_halted("t3_halt_seen", 100);
    check("t3_fault", fault, 1'b1);
    pulse_start();
    repeat (3) @(negedge clk);
    check("t3_fault_sticky", fault, 1'b1);
    check("t3_no_fetch", fetch_en, 1'b0);
    check("t3_not_busy", busy, 1'b0);
    check("t3_sb_drained", sbq.size(), 0);
    do_reset();

    // 4) JZ / JNZ at pc 2, both zero_flag values, restarting from HALT.
    for (int k = 0; k < 4; k++) begin
      logic [3:0] bop;
      bit         zf;
      int         exp_pc;
      bop    = (k < 2) ? 4'hD : 4'hE;
      zf     = k[0];
      exp_pc = ((bop == 4'hD) == zf) ? 4 : 3;
      clear_prog();
      mem_op[0] = 4'h1; mem_arg[0] = 8'd0;
      mem_op[1] = 4'h1; mem_arg[1] = 8'd0;
      mem_op[2] = bop;  mem_arg[2] = 8'd4;
      zero_flag = zf;
      fetch_lat = k;
      push_fetch(0); push_ex(1, 0); push_fetch(1); push_ex(1, 0);
      push_fetch(2); push_fetch(exp_pc);
      pulse_start();
      wait_halted("t4_halt_seen", 200);
      check("t4_pc", pc, exp_pc);
      check("t4_retired", retired, 4);
      check("t4_fault", fault, 1'b0);
      check("t4_sb_drained", sbq.size(), 0);
    end
    zero_flag = 1'b0;
    fetch_lat = 0;

    // 5a) is_ready never arrives -> fault after FETCH_TIMEOUT fetch cycles.
    do_reset();
    auto_fetch = 1'b0;
    is_ready   = 1'b0;
    push_fetch(0);
    pulse_start();
    begin
      int n;
      n = 0;
      for (int i = 0; i < 100 && !fault; i++) begin
        if (fetch_en) n++;
        @(negedge clk);
      end
      check("t5_timeout_fault", fault, 1'b1);
      check("t5_timeout_cycles", n, FETCH_TIMEOUT);
      check("t5_halted", halted, 1'b1);
    end
    check("t5_sb_drained", sbq.size(), 0);

    // 5b) is_ready already high on FETCH entry must not be captured.
    do_reset();
    control_bus = 4'hF; data = '0;
    is_ready    = 1'b1;
    push_fetch(0);
    pulse_start();
    repeat (4) @(negedge clk);
    check("t5_stale_fetch_en", fetch_en, 1'b1);
    check("t5_stale_busy", busy, 1'b1);
    is_ready = 1'b0;
    @(negedge clk);
    is_ready = 1'b1;
    @(negedge clk);
    is_ready = 1'b0;
    wait_halted("t5_stale_halt_seen", 20);
    check("t5_stale_retired", retired, 1);
    check("t5_stale_fault", fault, 1'b0);
    auto_fetch = 1'b1;

    // 6) Slow datapath: command held 10 cycles; start pulses while busy.
    clear_prog();
    mem_op[0] = 4'h3; mem_arg[0] = 8'hA5;
    ex_lat = 10;
    push_fetch(0); push_ex(3, 'hA5); push_fetch(1);
    pulse_start();
    begin
      int i;
      i = 0;
      while (!ex_valid && i < 20) begin @(negedge clk); i++; end
      check("t6_ex_valid_seen", ex_valid, 1'b1);
    end
    pulse_start();
    pulse_start();
    check("t6_busy", busy, 1'b1);
    wait_halted("t6_halt_seen", 100);
    check("t6_retired", retired, 2);
    check("t6_pc", pc, 1);
    check("t6_sb_drained", sbq.size(), 0);

    // 7) Reset in the middle of EXEC, then a fresh run from pc 0.
    clear_prog();
    mem_op[0] = 4'h2; mem_arg[0] = 8'd9;
    ex_lat = 20;
    push_fetch(0); push_ex(2, 9);
    pulse_start();
    begin
      int i;
      i = 0;
      while (!ex_valid && i < 20) begin @(negedge clk); i++; end
      check("t7_ex_valid_seen", ex_valid, 1'b1);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t7_async_ex_valid", ex_valid, 1'b0);
    check("t7_async_ex_op", ex_op, 0);
    check("t7_async_ex_arg", ex_arg, 0);
    check("t7_async_busy", busy, 1'b0);
    check("t7_async_retired", retired, 0);
    check("t7_sb_drained", sbq.size(), 0);
    @(negedge clk);
    rstn   = 1'b1;
    ex_lat = 0;
    clear_prog();
    push_fetch(0);
    pulse_start();
    wait_halted("t7_halt_seen", 50);
    check("t7_pc", pc, 0);
    check("t7_retired", retired, 1);

    // 8) Datapath op at pc 19 falls off the end -> fault.
    do_reset();
    clear_prog();
    mem_op[0]  = 4'hC; mem_arg[0]  = 8'd19;
    mem_op[19] = 4'h1; mem_arg[19] = 8'd1;
    push_fetch(0); push_fetch(19); push_ex(1, 1);
    pulse_start();
    wait_halted("t8_halt_seen", 100);
    check("t8_fault", fault, 1'b1);
    check("t8_pc", pc, 19);
    check("t8_ex_valid", ex_valid, 1'b0);
    check("t8_sb_drained", sbq.size(), 0);

    // 8b) Not-taken JZ at pc 19 also falls off the end.
    do_reset();
    clear_prog();
    mem_op[0]  = 4'hC; mem_arg[0]  = 8'd19;
    mem_op[19] = 4'hD; mem_arg[19] = 8'd5;
    zero_flag  = 1'b0;
    push_fetch(0); push_fetch(19);
    pulse_start();
    wait_halted("t8b_halt_seen", 100);
    check("t8b_fault", fault, 1'b1);
    check("t8b_pc", pc, 19);
    check("t8b_sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1, "watchdog expired");
  end

endmodule
